// File: rtl/bcx_compact_pkg.sv
// rtl/bcx_compact_pkg.sv - shared constants, state type and compact-word layout for the difficulty encoder
package bcx_compact_pkg;

    localparam int TARGET_BYTES = 32;
    localparam int MANT_BYTES   = 3;
    localparam int EXP_W        = 8;
    localparam int TARGET_W     = TARGET_BYTES * 8;
    localparam int MANT_W       = MANT_BYTES * 8;
    localparam int N_W          = 6;
    localparam int IDX_W        = 5;

    // Compact-word byte positions, shared with the validator's expansion logic
    localparam int CPT_EXP_LSB = 0;
    localparam int CPT_M2_LSB  = 8;
    localparam int CPT_M1_LSB  = 16;
    localparam int CPT_M0_LSB  = 24;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        PACK,
        DONE
    } state_t;

    function automatic logic [31:0] make_compact(input logic [MANT_W-1:0] mant,
                                                 input logic [EXP_W-1:0]  expo);
        logic [31:0] w;
        w = '0;
        w[CPT_EXP_LSB +: 8] = expo;
        w[CPT_M0_LSB  +: 8] = mant[7:0];
        w[CPT_M1_LSB  +: 8] = mant[15:8];
        w[CPT_M2_LSB  +: 8] = mant[23:16];
        return w;
    endfunction

endpackage

// File: rtl/compact_pack.sv
// rtl/compact_pack.sv - combinational mantissa extraction, normalisation, packing and lossless check
module compact_pack
    import bcx_compact_pkg::*;
(
    input  logic [TARGET_W-1:0] i_target,
    input  logic [N_W-1:0]      i_n,
    output logic [31:0]         o_compact,
    output logic                o_exact
);

    logic [N_W-1:0]      w_n_m3;
    logic [1:0]          w_pad;
    logic [MANT_W-1:0]   w_mant_raw;
    logic [MANT_W-1:0]   w_mant;
    logic [EXP_W-1:0]    w_exp;
    logic [EXP_W-1:0]    w_exp_m3;
    logic [1:0]          w_under;
    logic [TARGET_W-1:0] w_decoded;

    always_comb begin
        w_n_m3 = i_n - N_W'(MANT_BYTES);
        w_pad  = 2'd3 - i_n[1:0];

        if (i_n >= N_W'(MANT_BYTES)) begin
            w_mant_raw = MANT_W'(i_target >> {w_n_m3, 3'b000});
        end else begin
            w_mant_raw = i_target[MANT_W-1:0] << {w_pad, 3'b000};
        end

        // A set top bit would read as a sign, so shift it down a byte
        if (w_mant_raw[MANT_W-1]) begin
            w_mant = w_mant_raw >> 8;
            w_exp  = EXP_W'(i_n) + 8'd1;
        end else begin
            w_mant = w_mant_raw;
            w_exp  = EXP_W'(i_n);
        end

        w_exp_m3 = w_exp - 8'd3;
        w_under  = 2'd3 - w_exp[1:0];
        if (w_exp >= 8'd3) begin
            w_decoded = TARGET_W'(w_mant) << {w_exp_m3, 3'b000};
        end else begin
            w_decoded = TARGET_W'(w_mant) >> {w_under, 3'b000};
        end

        o_exact   = (w_decoded == i_target);
        o_compact = make_compact(w_mant, w_exp);
    end

endmodule

// File: rtl/difficulty_encoder.sv
// rtl/difficulty_encoder.sv - iterative 256-bit target to compact difficulty encoder, one byte scanned per cycle
module difficulty_encoder
    import bcx_compact_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [TARGET_W-1:0] target,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         compact,
    output logic                exact
);

    state_t              r_state;
    logic [TARGET_W-1:0] r_target;
    logic [IDX_W-1:0]    r_idx;
    logic [N_W-1:0]      r_n;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [31:0]         r_compact;
    logic                r_exact;

    logic [7:0]          w_byte;
    logic [31:0]         w_compact;
    logic                w_exact;

    assign w_byte = r_target[{r_idx, 3'b000} +: 8];

    compact_pack u_pack (
        .i_target  (r_target),
        .i_n       (r_n),
        .o_compact (w_compact),
        .o_exact   (w_exact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_target    <= '0;
            r_idx       <= '0;
            r_n         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_compact   <= '0;
            r_exact     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_target   <= target;
                        r_idx      <= IDX_W'(TARGET_BYTES - 1);
                        r_in_ready <= 1'b0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_byte != 8'd0) begin
                        r_n     <= N_W'(r_idx) + N_W'(1);
                        r_state <= PACK;
                    end else if (r_idx == '0) begin
                        r_n     <= '0;
                        r_state <= PACK;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                PACK: begin
                    r_compact   <= w_compact;
                    r_exact     <= w_exact;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign compact   = r_compact;
    assign exact     = r_exact;

endmodule

// File: tb/tb_difficulty_encoder.sv
// tb/tb_difficulty_encoder.sv - scoreboard bench for difficulty_encoder
module tb_difficulty_encoder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] target = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  compact;
    logic         exact;

    difficulty_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .target    (target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .compact   (compact),
        .exact     (exact)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] c;
        logic        e;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_acc = 0;
    int   last_hs = 0;
    bit   have_cur = 0;
    exp_t cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: sample 2ns after each rising edge, pop on first cycle of each result
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            have_cur = 0;
        end else begin
            if (have_cur && !out_valid) begin
                have_cur = 0;
                last_hs  = cyc;
            end
            if (out_valid) begin
                if (!have_cur) begin
                    if (sb.size() == 0) begin
                        check("spurious_out_valid", 64'(out_valid), 64'd0);
                    end else begin
                        cur = sb.pop_front();
                        have_cur = 1;
                        check("compact", 64'(compact), 64'(cur.c));
                        check("exact", 64'(exact), 64'(cur.e));
                        check("latency", 64'(cyc - cur.acc), 64'(cur.lat));
                    end
                end else begin
                    check("compact_stable", 64'(compact), 64'(cur.c));
                    check("exact_stable", 64'(exact), 64'(cur.e));
                end
                check("in_ready_busy", 64'(in_ready), 64'd0);
            end
        end
    end

    task automatic send(input logic [255:0] t, input logic [31:0] c, input logic e,
                        input int lat, input bit push);
        int   n;
        exp_t x;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        target   = t;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #2;
        last_acc = cyc;
        in_valid = 1'b0;
        if (push) begin
            x.c = c; x.e = e; x.lat = lat; x.acc = cyc;
            sb.push_back(x);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || out_valid || have_cur) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: pending %0d required 0", sb.size());
        end
    endtask

    localparam int NV = 8;
    logic [255:0] v_t   [NV];
    logic [31:0]  v_c   [NV];
    logic         v_e   [NV];
    int           v_lat [NV];

    initial begin
        v_t[0] = 256'hFFFF << 208;            v_c[0] = 32'hFFFF001D; v_e[0] = 1; v_lat[0] = 6;
        v_t[1] = 256'h80;                     v_c[1] = 32'h00800002; v_e[1] = 1; v_lat[1] = 33;
        v_t[2] = 256'h12345678;               v_c[2] = 32'h56341204; v_e[2] = 0; v_lat[2] = 30;
        v_t[3] = 256'h0;                      v_c[3] = 32'h00000000; v_e[3] = 1; v_lat[3] = 33;
        v_t[4] = 256'hFF << 248;              v_c[4] = 32'h00FF0021; v_e[4] = 1; v_lat[4] = 2;
        v_t[5] = 256'h1234;                   v_c[5] = 32'h00341202; v_e[5] = 1; v_lat[5] = 32;
        v_t[6] = 256'h800001;                 v_c[6] = 32'h00800004; v_e[6] = 0; v_lat[6] = 31;
        v_t[7] = (256'h1 << 200) | 256'h1;    v_c[7] = 32'h0000011A; v_e[7] = 0; v_lat[7] = 8;
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_compact", 64'(compact), 64'd0);
        check("rst_exact", 64'(exact), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            send(v_t[i], v_c[i], v_e[i], v_lat[i], 1'b1);
            wait_done();
        end

        // Backpressure with a second target waiting
        @(negedge clk);
        out_ready = 1'b0;
        send(256'h12345678, 32'h56341204, 1'b0, 30, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        target   = 256'hFFFF << 208;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_seen", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        send(256'hFFFF << 208, 32'hFFFF001D, 1'b1, 6, 1'b1);
        check("bp_accept_after_hs", 64'(last_acc - last_hs), 64'd1);
        wait_done();

        // Reset during SCAN aborts without emitting a result
        send(256'h12345678, 32'h0, 1'b0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_compact", 64'(compact), 64'd0);
        check("mid_rst_exact", 64'(exact), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        send(256'h12345678, 32'h56341204, 1'b0, 30, 1'b1);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
